// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch redirect controller
package fetch_pkg;

  typedef enum logic [1:0] {BOOT, FETCH, STALL, TRAP} state_t;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch PC owner, imem request handshake, branch redirect and flush
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [31:0] INSTR_BYTES = fetch_pkg::INSTR_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_branched,
  input  logic [31:0] ex_target,
  input  logic        hazard_stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        flush,
  output logic        if_kill,
  output logic        misalign_exc
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t      state;
  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_tgt;
  logic        trap_pend;

  logic        redirect;
  logic        misaligned;
  logic [31:0] tgt;

  assign redirect   = ex_valid & ex_branched;
  assign tgt        = {ex_target[31:2], 2'b00};
  assign misaligned = TRAP_EN & redirect & (|ex_target[1:0]);
  assign imem_addr  = pc;

  always_comb begin
    imem_req     = 1'b0;
    flush        = 1'b0;
    if_kill      = 1'b0;
    misalign_exc = 1'b0;
    if (!rst) begin
      unique case (state)
        FETCH: begin
          imem_req     = !redirect && !hazard_stall;
          flush        = redirect;
          misalign_exc = misaligned;
        end
        STALL: begin
          // A presented request is never withdrawn; a redirect only marks it wrong-path.
          imem_req     = 1'b1;
          flush        = redirect;
          misalign_exc = misaligned;
          if_kill      = imem_ready && (pend || redirect || trap_pend);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      pend      <= 1'b0;
      pend_tgt  <= 32'h0;
      trap_pend <= 1'b0;
    end else begin
      unique case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (redirect) begin
            if (misaligned) state <= TRAP;
            else            pc    <= tgt;
          end else if (!hazard_stall) begin
            if (imem_ready) pc    <= pc + INSTR_BYTES;
            else            state <= STALL;
          end
        end
        STALL: begin
          if (redirect && !misaligned) begin
            pend     <= 1'b1;
            pend_tgt <= tgt;
          end
          if (misaligned) trap_pend <= 1'b1;
          if (imem_ready) begin
            pend      <= 1'b0;
            trap_pend <= 1'b0;
            if (trap_pend || misaligned) begin
              state <= TRAP;
            end else begin
              state <= FETCH;
              // Same-cycle redirect is newer than any stored target.
              if (redirect)  pc <= tgt;
              else if (pend) pc <= pend_tgt;
              else           pc <= pc + INSTR_BYTES;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_branched = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic        hazard_stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        flush;
  logic        if_kill;
  logic        misalign_exc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_branched  (ex_branched),
    .ex_target    (ex_target),
    .hazard_stall (hazard_stall),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .flush        (flush),
    .if_kill      (if_kill),
    .misalign_exc (misalign_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic b, input logic [31:0] t,
                      input logic hz, input logic rdy);
    @(negedge clk);
    rst          = r;
    ex_valid     = v;
    ex_branched  = b;
    ex_target    = t;
    hazard_stall = hz;
    imem_ready   = rdy;
    #1;
  endtask

  initial begin
    // reset with a live redirect: every output must stay low
    step(1, 1, 1, 32'h500, 0, 1);
    step(1, 1, 1, 32'h500, 0, 1);
    chk("rst_req", imem_req, 0);
    chk("rst_flush", flush, 0);
    chk("rst_kill", if_kill, 0);
    chk("rst_mis", misalign_exc, 0);
    chk("rst_addr", imem_addr, 32'h0);

    // BOOT cycle ignores redirect
    step(0, 1, 1, 32'h500, 0, 1);
    chk("boot_req", imem_req, 0);
    chk("boot_flush", flush, 0);
    chk("boot_addr", imem_addr, 32'h0);

    // sequential fetch
    step(0, 0, 0, 0, 0, 1);
    chk("seq0_req", imem_req, 1);
    chk("seq0_addr", imem_addr, 32'h0);
    step(0, 0, 0, 0, 0, 1);
    chk("seq1_addr", imem_addr, 32'h4);
    step(0, 0, 0, 0, 0, 1);
    chk("seq2_addr", imem_addr, 32'h8);

    // redirect in FETCH
    step(0, 1, 1, 32'h100, 0, 1);
    chk("rd_flush", flush, 1);
    chk("rd_req", imem_req, 0);
    chk("rd_kill", if_kill, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_req2", imem_req, 1);
    chk("rd_kill2", if_kill, 0);
    chk("rd_flush2", flush, 0);

    // stall at 0x8, redirect to 0x200 in the 2nd low-ready cycle
    step(0, 1, 1, 32'h8, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("st1_addr", imem_addr, 32'h8);
    chk("st1_req", imem_req, 1);
    step(0, 1, 1, 32'h200, 0, 0);
    chk("st2_addr", imem_addr, 32'h8);
    chk("st2_req", imem_req, 1);
    chk("st2_flush", flush, 1);
    chk("st2_kill", if_kill, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("st3_addr", imem_addr, 32'h8);
    chk("st3_kill", if_kill, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("st_acc_kill", if_kill, 1);
    chk("st_acc_addr", imem_addr, 32'h8);
    step(0, 0, 0, 0, 0, 1);
    chk("st_new_addr", imem_addr, 32'h200);
    chk("st_new_kill", if_kill, 0);

    // pending 0x200 overridden by same-cycle redirect (low bits cleared) at accept
    step(0, 1, 1, 32'h8, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h200, 0, 0);
    step(0, 1, 1, 32'h301, 0, 1);
    chk("ovr_kill", if_kill, 1);
    chk("ovr_flush", flush, 1);
    chk("ovr_addr", imem_addr, 32'h8);
    step(0, 0, 0, 0, 0, 0);
    chk("ovr_new_addr", imem_addr, 32'h300);
    chk("ovr_new_kill", if_kill, 0);

    // stalled request survives hazard_stall, accepts without kill
    step(0, 0, 0, 0, 1, 1);
    chk("sthz_req", imem_req, 1);
    chk("sthz_kill", if_kill, 0);
    chk("sthz_addr", imem_addr, 32'h300);
    step(0, 0, 0, 0, 0, 1);
    chk("sthz_next", imem_addr, 32'h304);

    // hazard stall at 0x10, redirect to 0x40 on 2nd cycle
    step(0, 1, 1, 32'h10, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("hz1_req", imem_req, 0);
    chk("hz1_addr", imem_addr, 32'h10);
    step(0, 1, 1, 32'h40, 1, 1);
    chk("hz2_req", imem_req, 0);
    chk("hz2_flush", flush, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("hz_addr", imem_addr, 32'h40);
    chk("hz_req", imem_req, 1);

    // 32-bit wrap
    step(0, 1, 1, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_zero", imem_addr, 32'h0);

    // reset during STALL drops the request
    step(1, 0, 0, 0, 0, 0);
    chk("rststall_req", imem_req, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("reboot_req", imem_req, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("reboot_addr", imem_addr, 32'h0);
    chk("reboot_req2", imem_req, 1);

`ifdef PC_MISALIGN_TRAP_EN
    step(0, 1, 1, 32'h102, 0, 1);
    chk("trap_mis", misalign_exc, 1);
    chk("trap_flush", flush, 1);
    chk("trap_req", imem_req, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("trap_req2", imem_req, 0);
    chk("trap_addr", imem_addr, 32'h4);
    chk("trap_mis2", misalign_exc, 0);
    step(0, 1, 1, 32'h200, 0, 1);
    chk("trap_noflush", flush, 0);
    chk("trap_req3", imem_req, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("trap_restart", imem_addr, 32'h0);
    chk("trap_restart_req", imem_req, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h101, 0, 0);
    chk("trapst_mis", misalign_exc, 1);
    chk("trapst_req", imem_req, 1);
    chk("trapst_kill0", if_kill, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("trapst_kill", if_kill, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("trapst_req2", imem_req, 0);
`else
    step(0, 1, 1, 32'h102, 0, 1);
    chk("mis_flush", flush, 1);
    chk("mis_exc", misalign_exc, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_req", imem_req, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
